// File: rtl/nes_core.sv
// rtl/nes_core.sv - raster timing, tile fetch/pixel pipeline, pad poll and tone generator.
// Every registered output is computed for the position the counters move to on the same edge.
module nes_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] mapper_flags,
  input  logic [4:0]  audio_channels,
  input  logic [1:0]  joypad_data,
  input  logic [7:0]  memory_din_cpu,
  input  logic [7:0]  memory_din_ppu,
  output logic [21:0] memory_addr,
  output logic        memory_read_cpu,
  output logic        memory_read_ppu,
  output logic        memory_write,
  output logic [7:0]  memory_dout,
  output logic [5:0]  color,
  output logic [15:0] sample,
  output logic        joypad_strobe,
  output logic [1:0]  joypad_clock,
  output logic [8:0]  cycle,
  output logic [8:0]  scanline,
  output logic [31:0] dbgadr,
  output logic [1:0]  dbgctr
);

  localparam logic [21:0] NT_BASE  = 22'h380000;
  localparam logic [21:0] PAT_BASE = 22'h200000;
  localparam logic [21:0] PAD_BASE = 22'h3C0000;

  logic [8:0]  cyc_n, line_n;
  logic        vis_n, pix_win_n;
  logic [21:0] addr_n, pat_lo_addr;
  logic        rd_ppu_n, rd_cpu_n, wr_n;
  logic [7:0]  dout_n;
  logic        strobe_n, pad_sample, tone_n, tone;
  logic [1:0]  jclk_n;
  logic [5:0]  color_n;
  logic [15:0] sample_n;
  logic [2:0]  pop;
  logic [3:0]  hue, hue_offset;
  logic [7:0]  nt_lat, lo_lat, hi_lat;
  logic [7:0]  nt_sh, lo_sh, hi_sh;
  logic [7:0]  src_nt, src_lo, src_hi;
  logic [7:0]  pad1, pad2;
  logic        unused_bits;

  assign unused_bits = ^{mapper_flags, memory_din_cpu[7:4]};

  always_comb begin
    cyc_n  = cycle + 9'd1;
    line_n = scanline;
    if (cycle == 9'd340) begin
      cyc_n  = 9'd0;
      line_n = (scanline == 9'd261) ? 9'd0 : scanline + 9'd1;
    end
  end

  assign vis_n       = (line_n < 9'd240);
  assign pat_lo_addr = PAT_BASE + {10'd0, nt_lat, 4'h0} + {19'd0, line_n[2:0]};

  always_comb begin
    rd_ppu_n = 1'b0;
    rd_cpu_n = 1'b0;
    wr_n     = 1'b0;
    addr_n   = memory_addr;
    dout_n   = memory_dout;
    if (vis_n && (cyc_n < 9'd256)) begin
      case (cyc_n[2:0])
        3'd0: begin
          rd_ppu_n = 1'b1;
          addr_n   = NT_BASE + {12'd0, line_n[7:3], cyc_n[7:3]};
        end
        3'd2: begin
          rd_ppu_n = 1'b1;
          addr_n   = pat_lo_addr;
        end
        3'd4: begin
          rd_ppu_n = 1'b1;
          addr_n   = pat_lo_addr + 22'd8;
        end
        default: ;
      endcase
    end
    if (line_n == 9'd241) begin
      case (cyc_n)
        9'd32: begin
          wr_n   = 1'b1;
          addr_n = PAD_BASE;
          dout_n = pad1;
        end
        9'd33: begin
          wr_n   = 1'b1;
          addr_n = PAD_BASE + 22'd1;
          dout_n = pad2;
        end
        9'd34: begin
          rd_cpu_n = 1'b1;
          addr_n   = PAD_BASE + 22'd2;
        end
        default: ;
      endcase
    end
  end

  // On the last cycle of a tile the freshly fetched bytes feed the first pixel directly.
  always_comb begin
    if (cycle[2:0] == 3'd7) begin
      src_nt = nt_lat;
      src_lo = lo_lat;
      src_hi = hi_lat;
    end else begin
      src_nt = nt_sh;
      src_lo = lo_sh;
      src_hi = hi_sh;
    end
  end

  assign hue       = src_nt[3:0] + hue_offset;
  assign pix_win_n = vis_n && (cyc_n >= 9'd8) && (cyc_n <= 9'd263);
  assign color_n   = pix_win_n ? {src_hi[7], src_lo[7], hue} : 6'h0F;

  assign strobe_n   = (line_n == 9'd241) && (cyc_n == 9'd0);
  assign jclk_n     = ((line_n == 9'd241) && (cyc_n < 9'd32) && (cyc_n[1:0] == 2'd2)) ? 2'b11 : 2'b00;
  assign pad_sample = (scanline == 9'd241) && (cycle < 9'd32) && (cycle[1:0] == 2'd1);

  assign tone_n   = (cyc_n == 9'd0) ? ~tone : tone;
  assign pop      = {2'b0, audio_channels[0]} + {2'b0, audio_channels[1]} + {2'b0, audio_channels[2]}
                  + {2'b0, audio_channels[3]} + {2'b0, audio_channels[4]};
  assign sample_n = tone_n ? {2'b0, pop, 11'd0} : 16'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle           <= 9'd0;
      scanline        <= 9'd0;
      tone            <= 1'b0;
      hue_offset      <= 4'd0;
      pad1            <= 8'd0;
      pad2            <= 8'd0;
      nt_lat          <= 8'd0;
      lo_lat          <= 8'd0;
      hi_lat          <= 8'd0;
      nt_sh           <= 8'd0;
      lo_sh           <= 8'd0;
      hi_sh           <= 8'd0;
      color           <= 6'h0F;
      sample          <= 16'd0;
      memory_addr     <= 22'd0;
      memory_dout     <= 8'd0;
      memory_read_cpu <= 1'b0;
      memory_read_ppu <= 1'b0;
      memory_write    <= 1'b0;
      joypad_strobe   <= 1'b0;
      joypad_clock    <= 2'b00;
    end else if (ce) begin
      cycle           <= cyc_n;
      scanline        <= line_n;
      tone            <= tone_n;
      sample          <= sample_n;
      color           <= color_n;
      memory_addr     <= addr_n;
      memory_dout     <= dout_n;
      memory_read_cpu <= rd_cpu_n;
      memory_read_ppu <= rd_ppu_n;
      memory_write    <= wr_n;
      joypad_strobe   <= strobe_n;
      joypad_clock    <= jclk_n;
      nt_sh           <= src_nt;
      lo_sh           <= {src_lo[6:0], 1'b0};
      hi_sh           <= {src_hi[6:0], 1'b0};
      // Read data arrives during the access cycle and is taken on the edge leaving it.
      if (memory_read_ppu) begin
        case (cycle[2:0])
          3'd0:    nt_lat <= memory_din_ppu;
          3'd2:    lo_lat <= memory_din_ppu;
          3'd4:    hi_lat <= memory_din_ppu;
          default: ;
        endcase
      end
      if (memory_read_cpu)
        hue_offset <= memory_din_cpu[3:0];
      if (pad_sample) begin
        pad1[cycle[4:2]] <= joypad_data[0];
        pad2[cycle[4:2]] <= joypad_data[1];
      end
    end
  end

  assign dbgadr = {10'd0, memory_addr};
  assign dbgctr = cycle[2:1];

endmodule

// File: tb/tb_nes_core.sv
// tb/tb_nes_core.sv - directed bench for nes_core with write and pixel scoreboards.
module tb_nes_core;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [31:0] mapper_flags;
  logic [4:0]  audio_channels;
  logic [1:0]  joypad_data;
  logic [7:0]  memory_din_cpu, memory_din_ppu;
  logic [21:0] memory_addr;
  logic        memory_read_cpu, memory_read_ppu, memory_write;
  logic [7:0]  memory_dout;
  logic [5:0]  color;
  logic [15:0] sample;
  logic        joypad_strobe;
  logic [1:0]  joypad_clock;
  logic [8:0]  cycle, scanline;
  logic [31:0] dbgadr;
  logic [1:0]  dbgctr;

  nes_core dut (
    .clk(clk), .reset(reset), .ce(ce), .mapper_flags(mapper_flags),
    .audio_channels(audio_channels), .joypad_data(joypad_data),
    .memory_din_cpu(memory_din_cpu), .memory_din_ppu(memory_din_ppu),
    .memory_addr(memory_addr), .memory_read_cpu(memory_read_cpu),
    .memory_read_ppu(memory_read_ppu), .memory_write(memory_write),
    .memory_dout(memory_dout), .color(color), .sample(sample),
    .joypad_strobe(joypad_strobe), .joypad_clock(joypad_clock),
    .cycle(cycle), .scanline(scanline), .dbgadr(dbgadr), .dbgctr(dbgctr)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          ce_steps = 0;
  logic [7:0]  nt_v, lo_v, hi_v, cpu_v, pad1_v, pad2_v, pm1, pm2;
  logic [29:0] wq[$];
  logic [5:0]  pq[$];
  bit          pix_on = 1'b0;
  logic [8:0]  pix_line = 9'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pix(input int x, input logic [7:0] n, input logic [7:0] l,
                                     input logic [7:0] h, input logic [3:0] ho);
    int b;
    logic [3:0] hu;
    b  = 7 - (x % 8);
    hu = n[3:0] + ho;
    return {h[b], l[b], hu};
  endfunction

  task automatic push_pixels(input logic [3:0] ho);
    for (int x = 0; x < 256; x++) pq.push_back(pix(x, nt_v, lo_v, hi_v, ho));
  endtask

  task automatic step();
    logic [29:0] e;
    @(posedge clk);
    #1;
    if (ce && !reset) ce_steps++;
    memory_din_ppu = !memory_read_ppu ? 8'h00 :
                     (memory_addr[21:16] == 6'h38) ? nt_v : (memory_addr[3] ? hi_v : lo_v);
    memory_din_cpu = memory_read_cpu ? cpu_v : 8'h00;
    if (joypad_strobe) begin
      pm1 = pad1_v;
      pm2 = pad2_v;
    end else if (joypad_clock == 2'b11) begin
      pm1 = {1'b1, pm1[7:1]};
      pm2 = {1'b1, pm2[7:1]};
    end
    joypad_data = {pm2[0], pm1[0]};
    chk("access_exclusive", {31'd0, ($countones({memory_read_cpu, memory_read_ppu, memory_write}) <= 1)}, 32'd1);
    if (memory_write) begin
      if (wq.size() == 0) chk("write_unexpected", {2'b0, memory_addr, memory_dout}, 32'hFFFF_FFFF);
      else begin
        e = wq.pop_front();
        chk("write", {2'b0, memory_addr, memory_dout}, {2'b0, e});
      end
    end
    if (memory_read_cpu) chk("cpu_read_addr", {10'd0, memory_addr}, 32'h003C0002);
    if (pix_on && scanline == pix_line && cycle >= 9'd8 && cycle <= 9'd263) begin
      if (pq.size() == 0) chk("pixel_unexpected", {26'd0, color}, 32'hFFFF_FFFF);
      else chk("pixel", {26'd0, color}, {26'd0, pq.pop_front()});
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_cycle"}, {23'd0, cycle}, 32'd0);
    chk({tag, "_scanline"}, {23'd0, scanline}, 32'd0);
    chk({tag, "_color"}, {26'd0, color}, 32'h0F);
    chk({tag, "_sample"}, {16'd0, sample}, 32'd0);
    chk({tag, "_addr"}, {10'd0, memory_addr}, 32'd0);
    chk({tag, "_dout"}, {24'd0, memory_dout}, 32'd0);
    chk({tag, "_access"}, {29'd0, memory_read_cpu, memory_read_ppu, memory_write}, 32'd0);
    chk({tag, "_pad"}, {29'd0, joypad_strobe, joypad_clock}, 32'd0);
    chk({tag, "_dbg"}, dbgadr ^ {30'd0, dbgctr}, 32'd0);
  endtask

  initial begin
    int guard;
    reset = 1'b1; ce = 1'b1; mapper_flags = 32'hDEADBEEF; audio_channels = 5'b10101;
    joypad_data = 2'b00; memory_din_cpu = 8'h00; memory_din_ppu = 8'h00;
    nt_v = 8'h35; lo_v = 8'hF0; hi_v = 8'hAA; cpu_v = 8'h0D;
    pad1_v = 8'hA5; pad2_v = 8'h3C; pm1 = 8'hFF; pm2 = 8'hFF;
    step(); step();
    rst_chk("reset");
    reset = 1'b0;

    // reset during a pattern fetch
    step(); step();
    chk("fetch_cycle2_read", {31'd0, memory_read_ppu}, 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    rst_chk("midfetch_reset");
    ce_steps = 0;

    repeat (300) step();
    chk("pre_freeze_cycle", {23'd0, cycle}, 32'd300);
    ce = 1'b0;
    repeat (100) step();
    ce = 1'b1;
    chk("freeze_cycle", {23'd0, cycle}, 32'd300);
    chk("freeze_scanline", {23'd0, scanline}, 32'd0);
    chk("freeze_addr", dbgadr, 32'h00200358);
    chk("freeze_color", {26'd0, color}, 32'h0F);
    chk("freeze_dbgctr", {30'd0, dbgctr}, 32'd2);
    chk("freeze_sample", {16'd0, sample}, 32'd0);
    chk("freeze_access", {29'd0, memory_read_cpu, memory_read_ppu, memory_write}, 32'd0);

    repeat (40) step();
    chk("line0_end_cycle", {23'd0, cycle}, 32'd340);
    chk("line0_end_scanline", {23'd0, scanline}, 32'd0);
    push_pixels(4'd0);
    pix_line = 9'd1; pix_on = 1'b1;
    step();
    chk("line1_cycle", {23'd0, cycle}, 32'd0);
    chk("line1_scanline", {23'd0, scanline}, 32'd1);
    chk("tone_high_sample", {16'd0, sample}, 32'h1800);
    repeat (341) step();
    chk("tone_low_sample", {16'd0, sample}, 32'd0);
    chk("line1_pixels_drained", pq.size(), 32'd0);
    pix_on = 1'b0;

    wq.push_back({22'h3C0000, 8'hA5});
    wq.push_back({22'h3C0001, 8'h3C});
    guard = 0;
    while (!(scanline == 9'd241 && cycle == 9'd0) && guard < 95000) begin
      step();
      guard++;
    end
    chk("reach_241", {14'd0, scanline, cycle}, {14'd0, 9'd241, 9'd0});
    chk("strobe_on", {31'd0, joypad_strobe}, 32'd1);
    for (int c = 1; c <= 40; c++) begin
      step();
      if (cycle == 9'd1) chk("strobe_off", {31'd0, joypad_strobe}, 32'd0);
      if (cycle == 9'd2) chk("jclk_pulse", {30'd0, joypad_clock}, 32'd3);
      if (cycle == 9'd3) chk("jclk_idle", {30'd0, joypad_clock}, 32'd0);
      if (cycle == 9'd36) begin
        chk("addr_hold", {10'd0, memory_addr}, 32'h003C0002);
        chk("dout_hold", {24'd0, memory_dout}, 32'h3C);
      end
    end
    chk("writes_drained", wq.size(), 32'd0);

    nt_v = 8'h05;
    push_pixels(4'hD);
    pix_line = 9'd0; pix_on = 1'b1;
    guard = 0;
    while (!(scanline == 9'd0 && cycle == 9'd0) && guard < 10000) begin
      step();
      guard++;
    end
    chk("frame_wrap_steps", ce_steps, 32'd89342);
    chk("frame_wrap_pos", {14'd0, scanline, cycle}, 32'd0);
    chk("frame_start_sample", {16'd0, sample}, 32'd0);
    for (int c = 1; c <= 270; c++) begin
      step();
      if (cycle == 9'd7) chk("color_before_window", {26'd0, color}, 32'h0F);
      if (cycle == 9'd264) chk("color_after_window", {26'd0, color}, 32'h0F);
    end
    chk("frame2_pixels_drained", pq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
